// File: rtl/traffic_phase_scheduler_if.sv
// Control/status bundle between the intersection scheduler and its
// environment (tick source, ped button, light drivers, countdown display).
interface traffic_phase_scheduler_if;
  logic       tick;
  logic       ped_req;
  logic [1:0] led_a;
  logic [1:0] led_b;
  logic       walk;
  logic [5:0] timer_value;
  logic       ped_pending;

  modport master (
    output tick, ped_req,
    input  led_a, led_b, walk, timer_value, ped_pending
  );
  modport slave (
    input  tick, ped_req,
    output led_a, led_b, walk, timer_value, ped_pending
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase sequencer with all-red clearance and
// pedestrian walk service; every phase counts down in 1 Hz ticks.
module traffic_phase_scheduler #(
  parameter int T_GREEN_A = 15,
  parameter int T_GREEN_B = 15,
  parameter int T_YELLOW  = 3,
  parameter int T_ALLRED  = 1,
  parameter int T_WALK    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_phase_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    AR_A  = 3'd0,
    GRN_A = 3'd1,
    YEL_A = 3'd2,
    AR_B  = 3'd3,
    GRN_B = 3'd4,
    YEL_B = 3'd5,
    WALK  = 3'd6
  } state_t;

  state_t     state, state_nx, succ;
  logic [5:0] timer, timer_nx;
  logic       pend, pend_nx;
  logic       legal;
  logic [1:0] led_a, led_a_nx, led_b, led_b_nx;
  logic       walk, walk_nx;

  function automatic logic [5:0] dur(input state_t s);
    case (s)
      GRN_A:        dur = 6'(T_GREEN_A);
      GRN_B:        dur = 6'(T_GREEN_B);
      YEL_A, YEL_B: dur = 6'(T_YELLOW);
      WALK:         dur = 6'(T_WALK);
      default:      dur = 6'(T_ALLRED);
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    succ     = AR_A;
    legal    = 1'b1;
    pend_nx  = pend | (bus.ped_req && state != WALK);
    case (state)
      AR_A:    succ = GRN_A;
      GRN_A:   succ = YEL_A;
      YEL_A:   succ = AR_B;
      AR_B:    succ = GRN_B;
      GRN_B:   succ = YEL_B;
      // A request arriving on the exit tick itself is served immediately.
      YEL_B:   succ = (pend || bus.ped_req) ? WALK : AR_A;
      WALK:    succ = AR_A;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      state_nx = AR_A;
      timer_nx = 6'(T_ALLRED);
    end else if (bus.tick) begin
      if (timer > 6'd1) begin
        timer_nx = timer - 6'd1;
      end else begin
        state_nx = succ;
        timer_nx = dur(succ);
      end
    end
    if (state_nx == WALK && state != WALK) pend_nx = 1'b0;
    led_a_nx = (state_nx == GRN_A) ? 2'b01 : (state_nx == YEL_A) ? 2'b10 : 2'b00;
    led_b_nx = (state_nx == GRN_B) ? 2'b01 : (state_nx == YEL_B) ? 2'b10 : 2'b00;
    walk_nx  = (state_nx == WALK);
  end

  // Lamp outputs are decoded from the next state so they flip on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= AR_A;
      timer <= 6'(T_ALLRED);
      pend  <= 1'b0;
      led_a <= 2'b00;
      led_b <= 2'b00;
      walk  <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      pend  <= pend_nx;
      led_a <= led_a_nx;
      led_b <= led_b_nx;
      walk  <= walk_nx;
    end
  end

  assign bus.led_a       = led_a;
  assign bus.led_b       = led_b;
  assign bus.walk        = walk;
  assign bus.timer_value = timer;
  assign bus.ped_pending = pend;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomized and directed bench for traffic_phase_scheduler, compared every
// cycle against a phase-list reference model.
module tb_traffic_phase_scheduler;
  localparam int T_GREEN_A = 15;
  localparam int T_GREEN_B = 15;
  localparam int T_YELLOW  = 3;
  localparam int T_ALLRED  = 1;
  localparam int T_WALK    = 10;

  if ((T_GREEN_A < 1) || (T_GREEN_A > 63) || (T_GREEN_B < 1) || (T_GREEN_B > 63) ||
      (T_YELLOW < 1) || (T_YELLOW > 63) || (T_ALLRED < 1) || (T_ALLRED > 63) ||
      (T_WALK < 1) || (T_WALK > 63)) begin : g_bad_param
    initial begin
      $display("FAIL param_range: durations must lie in 1..63");
      $fatal(1, "illegal duration parameter");
    end
  end

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .T_GREEN_A(T_GREEN_A), .T_GREEN_B(T_GREEN_B), .T_YELLOW(T_YELLOW),
    .T_ALLRED(T_ALLRED), .T_WALK(T_WALK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase index into the fixed list
  // 0 AR_A, 1 GRN_A, 2 YEL_A, 3 AR_B, 4 GRN_B, 5 YEL_B, 6 WALK
  int dur_tab [7] = '{T_ALLRED, T_GREEN_A, T_YELLOW, T_ALLRED, T_GREEN_B, T_YELLOW, T_WALK};
  int m_ph, m_rem;
  bit m_pend, m_valid = 1'b0;

  always @(posedge clk) begin : model
    int p, r;
    bit pd;
    if (rst) begin
      m_ph    <= 0;
      m_rem   <= T_ALLRED;
      m_pend  <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      p  = m_ph;
      r  = m_rem;
      pd = m_pend;
      if (bus.ped_req && p != 6) pd = 1'b1;
      if (bus.tick) begin
        if (r > 1) r = r - 1;
        else begin
          if (p == 5)      p = pd ? 6 : 0;
          else if (p == 6) p = 0;
          else             p = p + 1;
          r = dur_tab[p];
          if (p == 6) pd = 1'b0;
        end
      end
      m_ph   <= p;
      m_rem  <= r;
      m_pend <= pd;
    end
  end

  function automatic int exp_la(input int p);
    return (p == 1) ? 1 : (p == 2) ? 2 : 0;
  endfunction
  function automatic int exp_lb(input int p);
    return (p == 4) ? 1 : (p == 5) ? 2 : 0;
  endfunction

  always @(negedge clk) begin : compare
    if (m_valid) begin
      chk("led_a",       int'(bus.led_a),       exp_la(m_ph));
      chk("led_b",       int'(bus.led_b),       exp_lb(m_ph));
      chk("walk",        int'(bus.walk),        int'(m_ph == 6));
      chk("timer_value", int'(bus.timer_value), m_rem);
      chk("ped_pending", int'(bus.ped_pending), int'(m_pend));
      chk("safety_roads", int'(bus.led_a == 2'b00 || bus.led_b == 2'b00), 1);
      chk("safety_walk", int'(!bus.walk || (bus.led_a == 2'b00 && bus.led_b == 2'b00)), 1);
    end
  end

  // Drive one cycle of inputs at a negedge; returns at the following negedge.
  task automatic step(input bit t, input bit p, input bit r);
    bus.tick    = t;
    bus.ped_req = p;
    rst         = r;
    @(negedge clk);
    bus.tick    = 1'b0;
    bus.ped_req = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic tick_until_yelb_last(input string name);
    int n = 0;
    while (!(bus.led_b == 2'b10 && bus.timer_value == 6'd1) && n < 80) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    chk(name, int'(bus.led_b == 2'b10 && bus.timer_value == 6'd1), 1);
  endtask

  initial begin
    int n;
    bus.tick = 1'b0; bus.ped_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_timer", int'(bus.timer_value), 1);
    chk("rst_leds", int'({bus.led_a, bus.led_b}), 0);
    chk("rst_pending", int'(bus.ped_pending), 0);

    step(1'b1, 1'b0, 1'b0);
    chk("first_led_a", int'(bus.led_a), 1);
    chk("first_timer", int'(bus.timer_value), 15);

    // Remaining 37 ticks of a plain 38-tick cycle.
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 1'b0);
    chk("cycle38_leds", int'({bus.led_a, bus.led_b}), 0);
    chk("cycle38_timer", int'(bus.timer_value), 1);
    chk("cycle38_walk", int'(bus.walk), 0);

    // Pedestrian request during GRN_A.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("ped_latch", int'(bus.ped_pending), 1);
    n = 0;
    while (!bus.walk && n < 60) begin step(1'b1, 1'b0, 1'b0); n++; end
    chk("walk_ticks", n, 37);
    chk("walk_on", int'(bus.walk), 1);
    chk("walk_timer", int'(bus.timer_value), 10);
    chk("walk_pend_clr", int'(bus.ped_pending), 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    chk("post_walk_walk", int'(bus.walk), 0);
    chk("post_walk_timer", int'(bus.timer_value), 1);

    // Request on the final YEL_B tick goes straight to WALK.
    tick_until_yelb_last("reach_yelb1");
    step(1'b1, 1'b1, 1'b0);
    chk("edge_req_walk", int'(bus.walk), 1);
    chk("edge_req_pend", int'(bus.ped_pending), 0);
    // Request held through WALK is not re-latched.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("held_pend", int'(bus.ped_pending), 0);
    tick_until_yelb_last("reach_yelb2");
    step(1'b1, 1'b0, 1'b0);
    chk("held_no_walk", int'(bus.walk), 0);
    chk("held_ar_a_timer", int'(bus.timer_value), 1);

    // Reset mid-GRN_B (timer 7) with tick and a pending request.
    step(1'b0, 1'b1, 1'b0);
    n = 0;
    while (!(bus.led_b == 2'b01 && bus.timer_value == 6'd7) && n < 60) begin
      step(1'b1, 1'b0, 1'b0); n++;
    end
    chk("reach_grnb7", int'(bus.led_b == 2'b01 && bus.timer_value == 6'd7), 1);
    chk("pend_before_rst", int'(bus.ped_pending), 1);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_leds", int'({bus.led_a, bus.led_b}), 0);
    chk("midrst_timer", int'(bus.timer_value), 1);
    chk("midrst_pend", int'(bus.ped_pending), 0);

    // Stall in GRN_A.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0);
    chk("stall_led_a", int'(bus.led_a), 1);
    chk("stall_timer", int'(bus.timer_value), 15);

    // Random traffic: about five full cycles of ticks with sparse requests.
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
